// File: rtl/vga_pkg.sv
// Shared raster timing constants for the video output path.
// Each supported mode gets its own constant set; only SVGA 800x600@60 exists today.
package vga_pkg;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

  localparam int SVGA_H_TOTAL = SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;
  localparam int SVGA_V_TOTAL = SVGA_V_ACTIVE + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

  localparam int VGA_X_W = 11;
  localparam int VGA_Y_W = 10;

  // Half-open window test lo <= val < hi, used for every region decode.
  function automatic logic in_window(input int val, input int lo, input int hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_raster_cnt.sv
// Horizontal/vertical raster position counter pair with a configurable reset position.
// Vertical advances only on the horizontal wrap.
module vga_raster_cnt
  import vga_pkg::*;
#(
  parameter int H_TOTAL = SVGA_H_TOTAL,
  parameter int V_TOTAL = SVGA_V_TOTAL,
  parameter int H_W     = VGA_X_W,
  parameter int V_W     = VGA_Y_W,
  parameter int H_RST   = 0,
  parameter int V_RST   = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  output logic [H_W-1:0] o_h,
  output logic [V_W-1:0] o_v
);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_INIT = H_W'(H_RST);
  localparam logic [V_W-1:0] V_INIT = V_W'(V_RST);

  logic [H_W-1:0] r_h;
  logic [V_W-1:0] r_v;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h <= H_INIT;
      r_v <= V_INIT;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  assign o_h = r_h;
  assign o_v = r_v;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: syncs, display enable, pixel coordinates, and a fetch
// request stream running REQ_LEAD cycles ahead of display enable. Held in reset until PLL lock.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = SVGA_H_ACTIVE,
  parameter int   H_FP     = SVGA_H_FP,
  parameter int   H_SYNC   = SVGA_H_SYNC,
  parameter int   H_BP     = SVGA_H_BP,
  parameter int   V_ACTIVE = SVGA_V_ACTIVE,
  parameter int   V_FP     = SVGA_V_FP,
  parameter int   V_SYNC   = SVGA_V_SYNC,
  parameter int   V_BP     = SVGA_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   REQ_LEAD = 2,
  parameter int   X_W      = VGA_X_W,
  parameter int   Y_W      = VGA_Y_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           locked,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_start,
  output logic           req_valid,
  output logic [X_W-1:0] req_x,
  output logic [Y_W-1:0] req_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic           w_rst;
  logic [X_W-1:0] w_h, w_rh;
  logic [Y_W-1:0] w_v, w_rv;
  logic           w_de, w_req_de, w_hs_act, w_vs_act;

  assign w_rst = rst | ~locked;

  vga_raster_cnt #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_W(X_W), .V_W(Y_W), .H_RST(0), .V_RST(0)
  ) u_disp_cnt (
    .i_clk(clk), .i_rst(w_rst), .o_h(w_h), .o_v(w_v)
  );

  // Request pair starts REQ_LEAD positions ahead, so it crosses every line/frame wrap early.
  vga_raster_cnt #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_W(X_W), .V_W(Y_W), .H_RST(REQ_LEAD), .V_RST(0)
  ) u_req_cnt (
    .i_clk(clk), .i_rst(w_rst), .o_h(w_rh), .o_v(w_rv)
  );

  assign w_de     = in_window(int'(w_h), 0, H_ACTIVE) && in_window(int'(w_v), 0, V_ACTIVE);
  assign w_req_de = in_window(int'(w_rh), 0, H_ACTIVE) && in_window(int'(w_rv), 0, V_ACTIVE);
  assign w_hs_act = in_window(int'(w_h), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
  assign w_vs_act = in_window(int'(w_v), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (w_rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      req_valid   <= 1'b0;
      req_x       <= '0;
      req_y       <= '0;
    end else begin
      hsync       <= w_hs_act ~^ HS_POL;
      vsync       <= w_vs_act ~^ VS_POL;
      de          <= w_de;
      x           <= w_de ? w_h : '0;
      y           <= w_de ? w_v : '0;
      line_start  <= (w_h == '0);
      frame_start <= (w_h == '0) && (w_v == '0);
      req_valid   <= w_req_de;
      req_x       <= w_req_de ? w_rh : '0;
      req_y       <= w_req_de ? w_rv : '0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator for SVGA 800x600 at 60 Hz, clocked by the 40 MHz pixel clock from the system PLL. It produces hsync, vsync, display-enable and pixel coordinates for the video output stage. It also produces a fetch request that runs REQ_LEAD cycles ahead of display-enable, so the frame-buffer read path can cover its memory latency. The block holds itself in reset until the PLL reports lock.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (cycles)
H_SYNC, 128, hsync pulse width (cycles)
H_BP, 88, horizontal back porch (cycles)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync pulse width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level
REQ_LEAD, 2, fetch-request lead in cycles; legal range 0 to (H_FP+H_SYNC+H_BP-1)
X_W, 11, x coordinate width
Y_W, 10, y coordinate width

Ports:
clk  in  1  40 MHz pixel clock (PLL outclk_0)
rst  in  1  synchronous reset, active-high
locked  in  1  PLL lock; treated as synchronous reset while low
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
de  out  1  display enable; high during the visible region
x  out  X_W  current pixel column; 0 when de low
y  out  Y_W  current pixel row; 0 when de low
line_start  out  1  one-cycle pulse on the first cycle of each line (h=0)
frame_start  out  1  one-cycle pulse at h=0, v=0
req_valid  out  1  fetch request for the pixel displayed REQ_LEAD cycles later
req_x  out  X_W  column of the requested pixel
req_y  out  Y_W  row of the requested pixel

Behaviour:
- Reset: clock and reset ports are clk and rst; rst is synchronous and active-high.
- Effective reset is rst | ~locked, sampled on clk. It clears both counter pairs.
- Output reset values:
  - hsync = ~HS_POL, vsync = ~VS_POL;
  - de, line_start, frame_start, req_valid = 0;
  - x, y, req_x, req_y = 0.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1056; V_TOTAL = 628. One frame is 663168 cycles.
- Display counters (h, v):
  - h counts 0..H_TOTAL-1, then wraps to 0.
  - v increments only when h wraps; v wraps 0..V_TOTAL-1.
  - The first cycle after effective reset releases has h=0, v=0.
- All outputs are registered: outputs in cycle n+1 decode the counters of cycle n (1-cycle latency). The first frame_start appears on the first cycle after release+1.
- Decodes, given counter values (h, v):
  - de = (h<H_ACTIVE) & (v<V_ACTIVE);
  - x = de ? h : 0; y = de ? v : 0;
  - hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (840..967);
  - vsync active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (601..604), across whole lines, changing at h=0;
  - line_start = (h==0); frame_start = (h==0)&(v==0).
- Request counters (rh, rv):
  - They step identically to (h, v), but reset to the position REQ_LEAD cycles ahead of (0,0).
  - Reset value of rh is REQ_LEAD and rv is 0; REQ_LEAD < H_TOTAL guarantees this.
  - req_valid/req_x/req_y use the de/x/y decode applied to (rh, rv), with the same 1-cycle register stage.
  - Invariant: if req_valid=1 with (req_x, req_y)=(X, Y) in cycle n, then de=1 with (x, y)=(X, Y) in cycle n+REQ_LEAD.
  - REQ_LEAD=0 makes req_* identical to de/x/y.
  - Wrap: the request pair crosses a line or frame boundary before the display pair does. The first request of a frame (0,0) is issued REQ_LEAD cycles before frame_start.
- Reset or loss of lock mid-frame: on the next clock edge all outputs return to reset values and counters restart from the reset positions. No partial-line completion.
- No handshake: the consumer must accept requests at one per cycle while req_valid=1.

Decomposition:
- Shared package vga_pkg: SVGA timing constants (the eight porch/sync/active values, H_TOTAL, V_TOTAL, X_W, Y_W). A future 640x480 mode adds a constant set there.
- One natural sub-module, vga_raster_cnt: the h/v counter pair with a reset-position parameter. It is instantiated twice, once for display and once for request, sharing the decode logic.

Test Plan:
- Hold rst=1, locked=1 for 5 cycles -> all outputs at reset values; release -> frame_start=1, line_start=1, de=1, x=0, y=0 one cycle after release.
- Free-run one line -> de high exactly 800 consecutive cycles. hsync goes active 840 cycles after line_start, stays active 128 cycles. Next line_start comes 1056 cycles after the previous one.
- Free-run 2 frames -> frame_start period 663168 cycles. vsync active for 4 lines (4224 cycles) beginning at line 601. Last visible pixel is x=799, y=599.
- REQ_LEAD=2 and REQ_LEAD=0 -> scoreboard every req (req_x, req_y) against de (x, y) exactly REQ_LEAD cycles later across the frame wrap. No missing or extra requests (480000 per frame).
- Drop locked for 3 cycles mid-line (h=400, v=300) -> outputs reset the next cycle. On re-lock, timing restarts at (0,0) with correct periods.
- Assert rst at h=1055, v=627 (simultaneous wrap) -> reset wins; the next frame starts cleanly with no double frame_start.
